// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-pipeline-to-AXI bridge.
// - Request codes driven by the cache pipeline arbiter.
// - Bridge FSM state encoding.
// - AXI burst-type constant and ID width.
// - Helpers that classify request codes as loads or stores.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    ReqNone       = 3'd0,
    ReqLoadBlock  = 3'd1,
    ReqLoadWord   = 3'd2,
    ReqWriteBlock = 3'd3,
    ReqWriteWord  = 3'd4
  } req_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAr   = 3'd1,
    StR    = 3'd2,
    StWr   = 3'd3,
    StB    = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam int unsigned AxiIdWidth   = 4;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;

  function automatic logic is_load(input logic [2:0] code);
    return (code == ReqLoadBlock) || (code == ReqLoadWord);
  endfunction

  function automatic logic is_store(input logic [2:0] code);
    return (code == ReqWriteBlock) || (code == ReqWriteWord);
  endfunction

endpackage

// File: rtl/cache_axi_wbeat.sv
// Write-data beat source for the bridge. Holds the store payload captured at
// request accept and presents wdata/wstrb/wlast for the current beat index.
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   load_i        capture payload (request accept cycle)
//   block_i       captured request is a block store
//   wblock_i      block payload, word 0 in the low bits
//   wword_i       single-word payload (lane positioned)
//   wstrb_i       single-word byte strobe
//   beat_i        current W beat index
//   wdata_o       AXI WDATA for the current beat
//   wstrb_o       AXI WSTRB for the current beat
//   wlast_o       AXI WLAST for the current beat
module cache_axi_wbeat #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned BEAT_WIDTH  = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              load_i,
  input  logic                              block_i,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] wblock_i,
  input  logic [DATA_WIDTH-1:0]             wword_i,
  input  logic [DATA_WIDTH/8-1:0]           wstrb_i,
  input  logic [BEAT_WIDTH-1:0]             beat_i,
  output logic [DATA_WIDTH-1:0]             wdata_o,
  output logic [DATA_WIDTH/8-1:0]           wstrb_o,
  output logic                              wlast_o
);

  logic                              block_q;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] wblock_q;
  logic [DATA_WIDTH-1:0]             wword_q;
  logic [DATA_WIDTH/8-1:0]           wstrb_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      block_q  <= 1'b0;
      wblock_q <= '0;
      wword_q  <= '0;
      wstrb_q  <= '0;
    end else if (load_i) begin
      block_q  <= block_i;
      wblock_q <= wblock_i;
      wword_q  <= wword_i;
      wstrb_q  <= wstrb_i;
    end
  end

  // Outputs depend only on captured payload and beat index, so they stay
  // stable while the slave stalls W (beat only advances on a handshake).
  always_comb begin
    if (block_q) begin
      wdata_o = wblock_q[int'(beat_i)*DATA_WIDTH +: DATA_WIDTH];
      wstrb_o = '1;
      wlast_o = (beat_i == BEAT_WIDTH'(BLOCK_WORDS - 1));
    end else begin
      wdata_o = wword_q;
      wstrb_o = wstrb_q;
      wlast_o = 1'b1;
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-pipeline-to-AXI4 bridge, one outstanding transaction.
// Accepts block/word loads and stores from the cache pipeline, runs each as
// an AXI4 INCR burst (block) or single beat (word), and returns load data
// plus a one-cycle task_finish_o pulse.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   req_i/ad_i                 request code and transfer address
//   wblock_i/wword_i/wword_en_i  store payloads and word strobe
//   rword_en_i                 ARSIZE for word loads
//   ready_o                    request accepted this cycle
//   task_finish_o              completion pulse
//   rblock_o/rword_o           load results, held until the next load
//   ar*/r*/aw*/w*/b*           AXI4 master channels
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           BLOCK_WORDS = 4,
  parameter logic [AxiIdWidth-1:0] AXI_ID      = '0
) (
  input  logic                              clk,
  input  logic                              rstn,
  // Cache pipeline side
  input  logic [2:0]                        req_i,
  input  logic [ADDR_WIDTH-1:0]             ad_i,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] wblock_i,
  input  logic [DATA_WIDTH-1:0]             wword_i,
  input  logic [DATA_WIDTH/8-1:0]           wword_en_i,
  input  logic [2:0]                        rword_en_i,
  output logic                              ready_o,
  output logic                              task_finish_o,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] rblock_o,
  output logic [DATA_WIDTH-1:0]             rword_o,
  // AR channel
  output logic [AxiIdWidth-1:0]             arid_o,
  output logic [ADDR_WIDTH-1:0]             araddr_o,
  output logic [7:0]                        arlen_o,
  output logic [2:0]                        arsize_o,
  output logic [1:0]                        arburst_o,
  output logic                              arvalid_o,
  input  logic                              arready_i,
  // R channel
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  input  logic [1:0]                        rresp_i,
  input  logic                              rlast_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  // AW channel
  output logic [AxiIdWidth-1:0]             awid_o,
  output logic [ADDR_WIDTH-1:0]             awaddr_o,
  output logic [7:0]                        awlen_o,
  output logic [2:0]                        awsize_o,
  output logic [1:0]                        awburst_o,
  output logic                              awvalid_o,
  input  logic                              awready_i,
  // W channel
  output logic [DATA_WIDTH-1:0]             wdata_o,
  output logic [DATA_WIDTH/8-1:0]           wstrb_o,
  output logic                              wlast_o,
  output logic                              wvalid_o,
  input  logic                              wready_i,
  // B channel
  input  logic [1:0]                        bresp_i,
  input  logic                              bvalid_i,
  output logic                              bready_o
);

  localparam int unsigned BeatW    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [2:0]  SizeWord = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [7:0]  LenBlock = 8'(BLOCK_WORDS - 1);

  state_e                            state_q, state_d;
  logic [2:0]                        req_q, req_d;
  logic [ADDR_WIDTH-1:0]             ad_q, ad_d;
  logic [2:0]                        rword_en_q, rword_en_d;
  logic [BeatW-1:0]                  beat_q, beat_d;
  logic                              aw_done_q, aw_done_d;
  logic                              w_done_q, w_done_d;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] rblock_q, rblock_d;
  logic [DATA_WIDTH-1:0]             rword_q, rword_d;

  logic accept;
  logic aw_fin, w_fin;
  logic wlast_beat;

  // Response codes carry no information this bridge acts on.
  logic unused_resp;
  assign unused_resp = ^{rresp_i, bresp_i};

  cache_axi_wbeat #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_WORDS(BLOCK_WORDS),
    .BEAT_WIDTH (BeatW)
  ) u_wbeat (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (accept),
    .block_i (req_i == ReqWriteBlock),
    .wblock_i(wblock_i),
    .wword_i (wword_i),
    .wstrb_i (wword_en_i),
    .beat_i  (beat_q),
    .wdata_o (wdata_o),
    .wstrb_o (wstrb_o),
    .wlast_o (wlast_beat)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      req_q      <= 3'd0;
      ad_q       <= '0;
      rword_en_q <= 3'd0;
      beat_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rblock_q   <= '0;
      rword_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ad_q       <= ad_d;
      rword_en_q <= rword_en_d;
      beat_q     <= beat_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rblock_q   <= rblock_d;
      rword_q    <= rword_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ad_d       = ad_q;
    rword_en_d = rword_en_q;
    beat_d     = beat_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rblock_d   = rblock_q;
    rword_d    = rword_q;
    accept     = 1'b0;
    aw_fin     = 1'b0;
    w_fin      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i != ReqNone) begin
          accept     = 1'b1;
          req_d      = req_i;
          ad_d       = ad_i;
          rword_en_d = rword_en_i;
          beat_d     = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (is_load(req_i)) begin
            state_d = StAr;
          end else if (is_store(req_i)) begin
            state_d = StWr;
          end else begin
            // Undefined codes complete without touching the bus so the
            // pipeline never deadlocks waiting for a finish pulse.
            state_d = StDone;
          end
        end
      end

      StAr: begin
        if (arready_i) begin
          state_d = StR;
        end
      end

      StR: begin
        if (rvalid_i) begin
          if (req_q == ReqLoadBlock) begin
            rblock_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
            beat_d = beat_q + BeatW'(1);
          end else begin
            rword_d = rdata_i;
          end
          if (rlast_i) begin
            state_d = StDone;
          end
        end
      end

      StWr: begin
        // AW and W progress independently; done flags remember whichever
        // side finished first.
        aw_fin = aw_done_q | awready_i;
        w_fin  = w_done_q;
        if (!w_done_q && wready_i) begin
          if (wlast_beat) begin
            w_fin = 1'b1;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          state_d = StB;
        end
      end

      StB: begin
        if (bvalid_i) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ready_o       = accept;
  assign task_finish_o = (state_q == StDone);
  assign rblock_o      = rblock_q;
  assign rword_o       = rword_q;

  assign arid_o    = AXI_ID;
  assign araddr_o  = ad_q;
  assign arlen_o   = (req_q == ReqLoadBlock) ? LenBlock : 8'd0;
  assign arsize_o  = (req_q == ReqLoadBlock) ? SizeWord : rword_en_q;
  assign arburst_o = AxiBurstIncr;
  assign arvalid_o = (state_q == StAr);
  assign rready_o  = (state_q == StR);

  assign awid_o    = AXI_ID;
  assign awaddr_o  = ad_q;
  assign awlen_o   = (req_q == ReqWriteBlock) ? LenBlock : 8'd0;
  assign awsize_o  = is_store(req_q) ? SizeWord : 3'd0;
  assign awburst_o = AxiBurstIncr;
  assign awvalid_o = (state_q == StWr) && !aw_done_q;
  assign wvalid_o  = (state_q == StWr) && !w_done_q;
  assign wlast_o   = wlast_beat;
  assign bready_o  = (state_q == StB);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: block/word loads, block/word stores
// with stalls, back-to-back acceptance and mid-transaction reset.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rstn;
  logic [2:0]   req;
  logic [31:0]  ad;
  logic [127:0] wblock;
  logic [31:0]  wword;
  logic [3:0]   wword_en;
  logic [2:0]   rword_en;
  logic         ready, task_finish;
  logic [127:0] rblock;
  logic [31:0]  rword;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp, bresp;
  logic         rlast, rvalid, rready;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic         bvalid, bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_i        (req),
    .ad_i         (ad),
    .wblock_i     (wblock),
    .wword_i      (wword),
    .wword_en_i   (wword_en),
    .rword_en_i   (rword_en),
    .ready_o      (ready),
    .task_finish_o(task_finish),
    .rblock_o     (rblock),
    .rword_o      (rword),
    .arid_o       (arid),
    .araddr_o     (araddr),
    .arlen_o      (arlen),
    .arsize_o     (arsize),
    .arburst_o    (arburst),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .rdata_i      (rdata),
    .rresp_i      (rresp),
    .rlast_i      (rlast),
    .rvalid_i     (rvalid),
    .rready_o     (rready),
    .awid_o       (awid),
    .awaddr_o     (awaddr),
    .awlen_o      (awlen),
    .awsize_o     (awsize),
    .awburst_o    (awburst),
    .awvalid_o    (awvalid),
    .awready_i    (awready),
    .wdata_o      (wdata),
    .wstrb_o      (wstrb),
    .wlast_o      (wlast),
    .wvalid_o     (wvalid),
    .wready_i     (wready),
    .bresp_i      (bresp),
    .bvalid_i     (bvalid),
    .bready_o     (bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int b;
    int cyc;
    logic tog;

    rstn = 1'b0; req = 3'd0; ad = '0; wblock = '0; wword = '0; wword_en = '0;
    rword_en = '0; arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    // Reset state
    chk("rst_ready", ready, 1'b0);
    chk("rst_finish", task_finish, 1'b0);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_rblock", rblock, 128'h0);
    chk("rst_rword", rword, 32'h0);
    chk("rst_ar_fields", {araddr, arlen, arsize}, 43'h0);
    chk("rst_aw_fields", {awaddr, awlen, awsize}, 43'h0);

    // LOAD_BLOCK with arready delayed two cycles
    req = 3'd1; ad = 32'h0000_1000;
    #1;
    chk("lb_ready", ready, 1'b1);
    tick();
    req = 3'd0;
    #1;
    chk("lb_arvalid", arvalid, 1'b1);
    chk("lb_ar_fields", {araddr, arlen, arsize, arburst}, {32'h1000, 8'd3, 3'd2, 2'b01});
    chk("lb_ready_busy", ready, 1'b0);
    tick();
    chk("lb_arvalid_wait", arvalid, 1'b1);
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    chk("lb_ar_drop", {arvalid, rready}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata  = 32'h11 * (i + 1);
      rlast  = (i == 3);
      #1;
      chk("lb_rready", rready, 1'b1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("lb_finish", task_finish, 1'b1);
    chk("lb_rblock", rblock, 128'h00000044_00000033_00000022_00000011);
    tick();
    chk("lb_finish_pulse", task_finish, 1'b0);

    // LOAD_WORD, zero-wait slave
    req = 3'd2; ad = 32'h1FD0_0004; rword_en = 3'd0; arready = 1'b1;
    #1;
    chk("lw_ready", ready, 1'b1);
    tick();
    req = 3'd0;
    #1;
    chk("lw_ar", {arvalid, araddr, arlen, arsize}, {1'b1, 32'h1FD0_0004, 8'd0, 3'd0});
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0001; rlast = 1'b1;
    #1;
    chk("lw_rready", rready, 1'b1);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("lw_finish_t3", task_finish, 1'b1);
    chk("lw_rword", rword, 32'hCAFE_0001);
    chk("lw_rblock_held", rblock, 128'h00000044_00000033_00000022_00000011);
    tick();
    chk("lw_finish_pulse", task_finish, 1'b0);

    // WRITE_BLOCK, wready toggling
    wblock = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; req = 3'd3; ad = 32'h0000_4000;
    #1;
    chk("wb_ready", ready, 1'b1);
    tick();
    req = 3'd0; wblock = '0;
    #1;
    chk("wb_aw", {awvalid, awaddr, awlen, awsize, awburst},
        {1'b1, 32'h4000, 8'd3, 3'd2, 2'b01});
    b = 0; cyc = 0; tog = 1'b0;
    while (b < 4 && cyc < 20) begin
      wready  = tog;
      awready = (cyc == 0);
      #1;
      chk("wb_wvalid", wvalid, 1'b1);
      chk("wb_wdata", wdata, 32'hA0 + b);
      chk("wb_wstrb", wstrb, 4'hF);
      chk("wb_wlast", wlast, (b == 3));
      if (cyc == 1) chk("wb_awvalid_drop", awvalid, 1'b0);
      if (wready) b++;
      tick();
      tog = ~tog;
      cyc++;
    end
    chk("wb_beats", b, 4);
    wready = 1'b0; awready = 1'b0;
    #1;
    chk("wb_in_b", {bready, wvalid, awvalid, task_finish}, 4'b1000);
    tick();
    chk("wb_b_wait", {bready, task_finish}, 2'b10);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    chk("wb_finish", task_finish, 1'b1);
    tick();

    // WRITE_WORD, W completes before AW
    req = 3'd4; ad = 32'h2000_0008; wword = 32'h0000_BEEF; wword_en = 4'b0011;
    #1;
    chk("ww1_ready", ready, 1'b1);
    tick();
    req = 3'd0; wword = '0; wword_en = '0; wready = 1'b1;
    #1;
    chk("ww1_w", {wvalid, wdata, wstrb, wlast}, {1'b1, 32'h0000_BEEF, 4'b0011, 1'b1});
    chk("ww1_aw", {awvalid, awaddr, awlen, awsize}, {1'b1, 32'h2000_0008, 8'd0, 3'd2});
    tick();
    wready = 1'b0; awready = 1'b1;
    #1;
    chk("ww1_half", {wvalid, awvalid, bready}, 3'b010);
    tick();
    awready = 1'b0;
    #1;
    chk("ww1_b", bready, 1'b1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    chk("ww1_finish", task_finish, 1'b1);
    tick();

    // WRITE_WORD, AW completes before W
    req = 3'd4; ad = 32'h2000_000C; wword = 32'h1234_0000; wword_en = 4'b1100;
    #1;
    tick();
    req = 3'd0; awready = 1'b1;
    #1;
    chk("ww2_both", {awvalid, wvalid}, 2'b11);
    tick();
    awready = 1'b0;
    #1;
    chk("ww2_half", {awvalid, wvalid, bready}, 3'b010);
    chk("ww2_w_stable", {wdata, wstrb, wlast}, {32'h1234_0000, 4'b1100, 1'b1});
    tick();
    wready = 1'b1;
    #1;
    chk("ww2_no_b", {wvalid, bready}, 2'b10);
    tick();
    wready = 1'b0;
    #1;
    chk("ww2_b", bready, 1'b1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    chk("ww2_finish", task_finish, 1'b1);
    tick();

    // Back-to-back LOAD_WORD with req held and zero-wait slave
    req = 3'd2; ad = 32'h0000_3000; rword_en = 3'd2; arready = 1'b1;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b2b_ready", ready, ((i % 4) == 0));
      chk("b2b_finish", task_finish, ((i % 4) == 3));
      chk("b2b_rready", rready, ((i % 4) == 2));
      if (i == 1) chk("b2b_arsize", arsize, 3'd2);
      tick();
    end
    #1;
    chk("b2b_ready_again", ready, 1'b1);
    tick();
    tick();
    chk("rst_mid_in_r", rready, 1'b1);
    rstn = 1'b0; req = 3'd0;
    tick();
    chk("rst_mid_outs", {ready, task_finish, arvalid, rready, awvalid, wvalid, bready}, 7'b0);
    chk("rst_mid_rword", rword, 32'h0);
    rstn = 1'b1; req = 3'd2;
    #1;
    chk("rst_mid_idle", ready, 1'b1);
    tick();
    req = 3'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
